// File: rtl/reg_fifo_param.sv
// Parameterised synchronous FIFO on a 2^M x N register array.
// It has circular pointers, occupancy-based status, a registered read port and sticky error flags.
module reg_fifo_param #(
   parameter int M      = 2,
   parameter int N      = 4,
   parameter int AF_LVL = 3
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         flush,
   input  logic         wrt_enab,
   input  logic [N-1:0] d_in,
   input  logic         rd_enab,
   output logic [N-1:0] d_out,
   output logic         full,
   output logic         empty,
   output logic         almost_full,
   output logic [M:0]   count,
   output logic         ovf,
   output logic         unf
);

   localparam int         Depth   = 1 << M;
   localparam logic [M:0] FullCnt = (M+1)'(Depth);
   localparam logic [M:0] AfCnt   = (M+1)'(AF_LVL);

   logic [N-1:0] mem_q [Depth];
   logic [M-1:0] wrPtr_q, wrPtr_d;
   logic [M-1:0] rdPtr_q, rdPtr_d;
   logic [M:0]   count_q, count_d;
   logic [N-1:0] dOut_q, dOut_d;
   logic         ovf_q, ovf_d;
   logic         unf_q, unf_d;
   logic         rdAccept, wrAccept;

   assign full        = (count_q == FullCnt);
   assign empty       = (count_q == '0);
   assign almost_full = (count_q >= AfCnt);
   assign count       = count_q;
   assign d_out       = dOut_q;
   assign ovf         = ovf_q;
   assign unf         = unf_q;

   // When full, a read in the same cycle frees a slot, so the write is still accepted.
   assign rdAccept = rd_enab & ~empty & ~flush;
   assign wrAccept = wrt_enab & (~full | rdAccept) & ~flush;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      dOut_d  = dOut_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else begin
         if (wrAccept) begin
            wrPtr_d = wrPtr_q + 1'b1;
         end
         if (rdAccept) begin
            rdPtr_d = rdPtr_q + 1'b1;
            dOut_d  = mem_q[rdPtr_q];
         end
         if (wrAccept && !rdAccept) begin
            count_d = count_q + 1'b1;
         end else if (rdAccept && !wrAccept) begin
            count_d = count_q - 1'b1;
         end
         if (wrt_enab && !wrAccept) begin
            ovf_d = 1'b1;
         end
         if (rd_enab && !rdAccept) begin
            unf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         dOut_q  <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         dOut_q  <= dOut_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Flush leaves the array contents alone; only reset wipes them.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wrAccept) begin
         mem_q[wrPtr_q] <= d_in;
      end
   end

endmodule

// File: tb/tb_reg_fifo_param.sv
// Self-checking bench for reg_fifo_param (M=2, N=4, AF_LVL=3).
// It combines a hand-written vector table with a queue reference model and a read-data scoreboard.
module tb_reg_fifo_param;

   logic       clk;
   logic       clr;
   logic       flush;
   logic       wrtEnab;
   logic [3:0] dIn;
   logic       rdEnab;
   logic [3:0] dOut;
   logic       full;
   logic       empty;
   logic       almostFull;
   logic [2:0] count;
   logic       ovf;
   logic       unf;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      logic       fl;
      logic       wr;
      logic       rd;
      logic [3:0] din;
      int         expCount;
      logic       expOvf;
      logic       expUnf;
      logic [3:0] expDout;
   } vec_t;

   vec_t vecs[$];
   int   modelQ[$];
   int   readQ[$];
   int   mDout;
   logic mOvf;
   logic mUnf;

   reg_fifo_param #(.M(2), .N(4), .AF_LVL(3)) dut (
      .clk         (clk),
      .clr         (clr),
      .flush       (flush),
      .wrt_enab    (wrtEnab),
      .d_in        (dIn),
      .rd_enab     (rdEnab),
      .d_out       (dOut),
      .full        (full),
      .empty       (empty),
      .almost_full (almostFull),
      .count       (count),
      .ovf         (ovf),
      .unf         (unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkModelState();
      int sz;
      sz = modelQ.size();
      checkOutput("count", int'(count), sz);
      checkOutput("full", int'(full), (sz == 4) ? 1 : 0);
      checkOutput("empty", int'(empty), (sz == 0) ? 1 : 0);
      checkOutput("almost_full", int'(almostFull), (sz >= 3) ? 1 : 0);
      checkOutput("ovf", int'(ovf), int'(mOvf));
      checkOutput("unf", int'(unf), int'(mUnf));
      checkOutput("d_out_hold", int'(dOut), mDout);
   endtask

   // Drive one cycle at the falling edge, advance the model, then check just after the rising edge.
   task automatic applyStimulus(input logic fl, input logic wr, input logic rd, input logic [3:0] din);
      logic rdOk;
      logic wrOk;
      @(negedge clk);
      flush   = fl;
      wrtEnab = wr;
      rdEnab  = rd;
      dIn     = din;
      if (fl) begin
         modelQ.delete();
         mOvf = 1'b0;
         mUnf = 1'b0;
      end else begin
         rdOk = rd && (modelQ.size() > 0);
         wrOk = wr && ((modelQ.size() < 4) || rdOk);
         if (rdOk) readQ.push_back(modelQ.pop_front());
         if (wrOk) modelQ.push_back(int'(din));
         if (wr && !wrOk) mOvf = 1'b1;
         if (rd && !rdOk) mUnf = 1'b1;
      end
      @(posedge clk);
      #1;
      if (readQ.size() > 0) begin
         mDout = readQ.pop_front();
         checkOutput("scoreboard_read", int'(dOut), mDout);
      end
      checkModelState();
   endtask

   task automatic addVec(input logic fl, input logic wr, input logic rd, input logic [3:0] din,
                         input int c, input logic o, input logic u, input logic [3:0] d);
      vec_t v;
      v.fl = fl; v.wr = wr; v.rd = rd; v.din = din;
      v.expCount = c; v.expOvf = o; v.expUnf = u; v.expDout = d;
      vecs.push_back(v);
   endtask

   initial begin
      addVec(0, 1, 0, 4'h1, 1, 0, 0, 4'h0);
      addVec(0, 1, 0, 4'h2, 2, 0, 0, 4'h0);
      addVec(0, 1, 0, 4'h3, 3, 0, 0, 4'h0);
      addVec(0, 1, 0, 4'h4, 4, 0, 0, 4'h0);
      addVec(0, 1, 0, 4'hF, 4, 1, 0, 4'h0);
      addVec(0, 0, 1, 4'h0, 3, 1, 0, 4'h1);
      addVec(0, 0, 1, 4'h0, 2, 1, 0, 4'h2);
      addVec(0, 0, 1, 4'h0, 1, 1, 0, 4'h3);
      addVec(0, 0, 1, 4'h0, 0, 1, 0, 4'h4);
      addVec(0, 0, 1, 4'h0, 0, 1, 1, 4'h4);
      addVec(1, 0, 0, 4'h0, 0, 0, 0, 4'h4);
      addVec(0, 1, 0, 4'h1, 1, 0, 0, 4'h4);
      addVec(0, 1, 0, 4'h2, 2, 0, 0, 4'h4);
      addVec(0, 1, 0, 4'h3, 3, 0, 0, 4'h4);
      addVec(0, 1, 0, 4'h4, 4, 0, 0, 4'h4);
      addVec(0, 1, 1, 4'hA, 4, 0, 0, 4'h1);
      addVec(0, 0, 1, 4'h0, 3, 0, 0, 4'h2);
      addVec(0, 0, 1, 4'h0, 2, 0, 0, 4'h3);
      addVec(0, 0, 1, 4'h0, 1, 0, 0, 4'h4);
      addVec(0, 0, 1, 4'h0, 0, 0, 0, 4'hA);
      addVec(0, 1, 1, 4'h7, 1, 0, 1, 4'hA);
      addVec(0, 0, 1, 4'h0, 0, 0, 1, 4'h7);

      mDout   = 0;
      mOvf    = 1'b0;
      mUnf    = 1'b0;
      clr     = 1'b1;
      flush   = 1'b0;
      wrtEnab = 1'b0;
      rdEnab  = 1'b0;
      dIn     = 4'h0;
      #12;
      checkOutput("reset_count", int'(count), 0);
      checkOutput("reset_empty", int'(empty), 1);
      checkOutput("reset_full", int'(full), 0);
      checkOutput("reset_af", int'(almostFull), 0);
      checkOutput("reset_dout", int'(dOut), 0);
      checkOutput("reset_flags", int'({ovf, unf}), 0);
      @(negedge clk);
      clr = 1'b0;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].fl, vecs[i].wr, vecs[i].rd, vecs[i].din);
         checkOutput($sformatf("vec%0d_count", i), int'(count), vecs[i].expCount);
         checkOutput($sformatf("vec%0d_ovf", i), int'(ovf), int'(vecs[i].expOvf));
         checkOutput($sformatf("vec%0d_unf", i), int'(unf), int'(vecs[i].expUnf));
         checkOutput($sformatf("vec%0d_dout", i), int'(dOut), int'(vecs[i].expDout));
      end

      // Asynchronous clear in the middle of a cycle with two entries held.
      applyStimulus(1, 0, 0, 4'h0);
      applyStimulus(0, 1, 0, 4'h5);
      applyStimulus(0, 1, 0, 4'h6);
      checkOutput("pre_clr_count", int'(count), 2);
      @(negedge clk);
      wrtEnab = 1'b0;
      #2;
      clr = 1'b1;
      #1;
      modelQ.delete();
      mDout = 0;
      mOvf  = 1'b0;
      mUnf  = 1'b0;
      checkOutput("async_clr_count", int'(count), 0);
      checkOutput("async_clr_empty", int'(empty), 1);
      checkOutput("async_clr_dout", int'(dOut), 0);
      checkOutput("async_clr_flags", int'({ovf, unf}), 0);
      #1;
      clr = 1'b0;
      applyStimulus(0, 0, 1, 4'h0);
      checkOutput("post_clr_read_unf", int'(unf), 1);
      checkOutput("post_clr_read_dout", int'(dOut), 0);
      checkOutput("post_clr_read_count", int'(count), 0);

      // A flush while full also discards that cycle's write and read requests.
      applyStimulus(0, 1, 0, 4'h9);
      applyStimulus(0, 1, 0, 4'h8);
      applyStimulus(0, 1, 0, 4'h7);
      applyStimulus(0, 1, 0, 4'h6);
      applyStimulus(1, 1, 1, 4'h3);
      checkOutput("flush_ignores_io_dout", int'(dOut), 0);
      applyStimulus(0, 1, 0, 4'hC);
      applyStimulus(0, 0, 1, 4'h0);
      checkOutput("flush_then_read", int'(dOut), 12);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
